alu_pipe: RTL and testbench

//   Pipelined, parametrised integer ALU. Next generation of the single-register arith/logic unit.

---
 rtl/alu_pipe.sv | 162 ++++++++++++++++
 tb/tb_alu_pipe.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined integer ALU with valid/ready handshakes and tag pass-through
// Define ALU_FLAGS_EN to build the out_zero/out_carry/out_ovf flag outputs.
module alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CMD_WIDTH  = 4,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic                  sign,
  input  logic [CMD_WIDTH-1:0]  cmd,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
`ifdef ALU_FLAGS_EN
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_ovf,
`endif
  output logic                  out_err
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [CMD_WIDTH-1:0] CMD_AND = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] CMD_OR  = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_XOR = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_SLT = CMD_WIDTH'(3);
  localparam logic [CMD_WIDTH-1:0] CMD_ADD = CMD_WIDTH'(4);
  localparam logic [CMD_WIDTH-1:0] CMD_SUB = CMD_WIDTH'(5);
  localparam logic [CMD_WIDTH-1:0] CMD_SLL = CMD_WIDTH'(6);
  localparam logic [CMD_WIDTH-1:0] CMD_SRL = CMD_WIDTH'(7);
  localparam logic [CMD_WIDTH-1:0] CMD_SRA = CMD_WIDTH'(8);

  logic                  ready_q;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic                  s1_sign;
  logic [CMD_WIDTH-1:0]  s1_cmd;
  logic [TAG_WIDTH-1:0]  s1_tag;

  logic                  s1_en;
  logic                  s2_en;
  logic                  accept;
  logic [SHW-1:0]        shamt;
  logic                  slt_bit;
  logic [DATA_WIDTH-1:0] res;
  logic                  err;

  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_valid || s2_en;
  // ready_q keeps in_ready low during reset and for the first edge after release
  assign in_ready = ready_q && s1_en;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sign  <= 1'b0;
      s1_cmd   <= '0;
      s1_tag   <= '0;
    end else begin
      if (s1_en) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_a    <= in1;
        s1_b    <= in2;
        s1_sign <= sign;
        s1_cmd  <= cmd;
        s1_tag  <= in_tag;
      end
    end
  end

  assign shamt   = s1_b[SHW-1:0];
  assign slt_bit = s1_sign ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);

  always_comb begin
    res = '0;
    err = 1'b0;
    case (s1_cmd)
      CMD_AND: res = s1_a & s1_b;
      CMD_OR:  res = s1_a | s1_b;
      CMD_XOR: res = s1_a ^ s1_b;
      CMD_SLT: res = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
      CMD_ADD: res = s1_a + s1_b;
      CMD_SUB: res = s1_a - s1_b;
      CMD_SLL: res = s1_a << shamt;
      CMD_SRL: res = s1_a >> shamt;
      CMD_SRA: res = $signed(s1_a) >>> shamt;
      default: err = 1'b1;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic zero_c;
  logic carry_c;
  logic ovf_c;

  // Carry on ADD shows up as the wrapped sum falling below an operand.
  always_comb begin
    zero_c  = !err && (res == '0);
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    if (s1_cmd == CMD_ADD) begin
      carry_c = res < s1_a;
      ovf_c   = (s1_a[MSB] == s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
    end else if (s1_cmd == CMD_SUB) begin
      carry_c = s1_a < s1_b;
      ovf_c   = (s1_a[MSB] != s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (s2_en && s1_valid) begin
      out_zero  <= zero_c;
      out_carry <= carry_c;
      out_ovf   <= ovf_c;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_tag  <= s1_tag;
        out_err  <= err;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized self-checking bench for alu_pipe against a behavioural model
// Flag outputs are connected and checked when ALU_FLAGS_EN is defined.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int TW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          sign;
  logic [CW-1:0] cmd;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_err;
  logic          out_zero;
  logic          out_carry;
  logic          out_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          err;
    logic [TW-1:0] tag;
    logic          z;
    logic          c;
    logic          v;
  } exp_t;

  exp_t q[$];

  alu_pipe #(.DATA_WIDTH(W), .CMD_WIDTH(CW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .sign(sign), .cmd(cmd), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
`ifdef ALU_FLAGS_EN
    .out_zero(out_zero), .out_carry(out_carry), .out_ovf(out_ovf),
`endif
    .out_err(out_err)
  );

`ifndef ALU_FLAGS_EN
  assign out_zero  = 1'b0;
  assign out_carry = 1'b0;
  assign out_ovf   = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [CW-1:0] c, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic s, input logic [TW-1:0] t);
    exp_t   e;
    longint sa, sb, r;
    int     sh;
    logic [63:0] usum;
    e  = '0;
    e.tag = t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (c)
      4'd0: e.data = a & b;
      4'd1: e.data = a | b;
      4'd2: e.data = a ^ b;
      4'd3: e.data = s ? {31'b0, sa < sb} : {31'b0, a < b};
      4'd4: begin
        e.data = a + b;
        usum = {32'b0, a} + {32'b0, b};
        e.c = usum > 64'hFFFF_FFFF;
        r = sa + sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd5: begin
        e.data = a - b;
        e.c = a < b;
        r = sa - sb;
        e.v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd6: e.data = a << sh;
      4'd7: e.data = a >> sh;
      4'd8: begin
        r = sa >>> sh;
        e.data = r[31:0];
      end
      default: e.err = 1'b1;
    endcase
    e.z = !e.err && (e.data == 32'b0);
`ifndef ALU_FLAGS_EN
    e.z = 1'b0;
    e.c = 1'b0;
    e.v = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom % 5)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.data = out_data;
    o.err  = out_err;
    o.tag  = out_tag;
    o.z    = out_zero;
    o.c    = out_carry;
    o.v    = out_ovf;
    return o;
  endfunction

  task automatic drive_op(input logic v, input logic [CW-1:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s, input logic [TW-1:0] t);
    in_valid = v;
    cmd      = c;
    in1      = a;
    in2      = b;
    sign     = s;
    in_tag   = t;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive_op(1'b0, '0, '0, '0, 1'b0, '0);
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, in_ready, out_err, out_data, out_zero, out_carry, out_ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs valid=%b ready=%b err=%b data=%h flags=%b%b%b required all 0",
               out_valid, in_ready, out_err, out_data, out_zero, out_carry, out_ovf);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_early in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [CW-1:0] vc [9] = '{4'd4, 4'd3, 4'd3, 4'd5, 4'd8, 4'd7, 4'd6, 4'd15, 4'd0};
    logic [W-1:0]  va [9] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                             32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1234_5678, 32'hF0F0_F0F0};
    logic [W-1:0]  vb [9] = '{32'h1, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'd4, 32'd4, 32'd33,
                             32'h9ABC_DEF0, 32'hFF00_FF00};
    logic          vs [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0]  vd [9] = '{32'h0, 32'h1, 32'h0, 32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
                             32'h2, 32'h0, 32'hF000_F000};
    logic          ve [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_t e;
    exp_t o;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive_op(1'b1, vc[i], va[i], vb[i], vs[i], TW'(i + 1));
      e = model(vc[i], va[i], vb[i], vs[i], TW'(i + 1));
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL dir%0d_in_ready in_ready=%b required 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_early out_valid=%b required 0 one edge after accept", i, out_valid);
      end
      @(negedge clk);
      o = observed();
      total++;
      if (out_valid !== 1'b1 || out_data !== vd[i] || out_err !== ve[i] || o !== e) begin
        bad++;
        $display("FAIL dir%0d_result valid=%b data=%h err=%b obs=%h required data=%h err=%b model=%h",
                 i, out_valid, out_data, out_err, o, vd[i], ve[i], e);
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL dir_drain out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_stall();
    int   sent = 0;
    int   got = 0;
    logic hold = 1'b0;
    exp_t held;
    exp_t o;
    q.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      if (sent < 6) drive_op(1'b1, CW'(sent % 9), rnd_operand(), rnd_operand(), 1'($urandom), TW'(sent + 1));
      else in_valid = 1'b0;
      #4;
      o = observed();
      total++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        bad++;
        $display("FAIL stall_in_ready cyc=%0d in_ready=%b in_flight=%0d out_ready=%b", cyc, in_ready, q.size(), out_ready);
      end
      if (hold) begin
        total++;
        if (out_valid !== 1'b1 || o !== held) begin
          bad++;
          $display("FAIL stall_hold cyc=%0d valid=%b obs=%h required %h", cyc, out_valid, o, held);
        end
      end
      if (out_valid) begin
        total++;
        if (q.size() == 0 || o !== q[0]) begin
          bad++;
          $display("FAIL stall_order cyc=%0d obs=%h queued=%0d", cyc, o, q.size());
        end
      end
      if (out_valid && out_ready && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(cmd, in1, in2, sign, in_tag));
        sent++;
      end
      hold = out_valid && !out_ready;
      held = o;
    end
    total++;
    if (got != 6 || q.size() != 0) begin
      bad++;
      $display("FAIL stall_count received=%0d left=%0d required 6 and 0", got, q.size());
    end
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    exp_t held;
    exp_t o;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 380) ? 1'b1 : ($urandom % 3 != 0);
      if (cyc < 370 && ($urandom % 4 != 0))
        drive_op(1'b1, CW'($urandom % 16), rnd_operand(), rnd_operand(), 1'($urandom), TW'($urandom));
      else
        in_valid = 1'b0;
      #4;
      o = observed();
      total++;
      if (in_ready !== ((q.size() < 2) || out_ready)) begin
        bad++;
        $display("FAIL rnd_in_ready cyc=%0d in_ready=%b in_flight=%0d", cyc, in_ready, q.size());
      end
      if (hold) begin
        total++;
        if (out_valid !== 1'b1 || o !== held) begin
          bad++;
          $display("FAIL rnd_hold cyc=%0d valid=%b obs=%h required %h", cyc, out_valid, o, held);
        end
      end
      if (out_valid) begin
        total++;
        if (q.size() == 0 || o !== q[0]) begin
          bad++;
          $display("FAIL rnd_result cyc=%0d obs=%h queued=%0d", cyc, o, q.size());
        end
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(cmd, in1, in2, sign, in_tag));
      hold = out_valid && !out_ready;
      held = o;
    end
    total++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      bad++;
      $display("FAIL rnd_drain out_valid=%b left=%0d required 0 and 0", out_valid, q.size());
    end
  endtask

  task automatic test_reset_inflight();
    exp_t e;
    int   waited;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_op(1'b1, 4'd4, 32'd100 + i, 32'd1, 1'b0, TW'(9 + i));
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_setup out_valid=%b required 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_async out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rst_mid_stale cyc=%0d out_valid=%b required 0", i, out_valid);
      end
    end
    drive_op(1'b1, 4'd5, 32'd50, 32'd8, 1'b0, 4'd3);
    e = model(4'd5, 32'd50, 32'd8, 1'b0, 4'd3);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_ready in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 5) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (out_valid !== 1'b1 || observed() !== e || out_data !== 32'd42) begin
      bad++;
      $display("FAIL rst_mid_new valid=%b obs=%h required %h (data 0000002a)", out_valid, observed(), e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
